// File: rtl/img_proc_pkg.sv
// Shared constants for the frame-level image processing stages.
package img_proc_pkg;
  localparam int DEF_X_W   = 10;
  localparam int DEF_Y_W   = 10;
  localparam int DEF_CNT_W = 20;
  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
endpackage

// File: rtl/sync_edge_det.sv
// Registers vsync/href and emits frame_start, frame_end and line_end pulses.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  input  logic href_i,
  output logic frame_start_o,
  output logic frame_end_o,
  output logic line_end_o
);
  logic vsync_q;
  logic href_q;

  // vsync_q resets high so a frame already in progress at reset release
  // is not mistaken for a fresh frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
    end
  end

  assign frame_start_o = vsync_i & ~vsync_q;
  assign frame_end_o   = ~vsync_i & vsync_q;
  assign line_end_o    = ~href_i & href_q;
endmodule

// File: rtl/bin_bbox_detect.sv
// Per-frame bounding box and pixel count of a 1-bit mask stream, published at frame end.
module bin_bbox_detect
  import img_proc_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_PIXELS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_bit,
  output logic [X_W-1:0]   box_x_min,
  output logic [X_W-1:0]   box_x_max,
  output logic [Y_W-1:0]   box_y_min,
  output logic [Y_W-1:0]   box_y_max,
  output logic [CNT_W-1:0] box_pix_cnt,
  output logic             box_valid,
  output logic             box_update
);
  logic frame_start, frame_end, line_end;

  sync_edge_det u_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync_i       (per_frame_vsync),
    .href_i        (per_frame_href),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .line_end_o    (line_end)
  );

  logic             armed_q, armed_d;
  logic [X_W-1:0]   x_cnt_q, x_cnt_d, x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_W-1:0]   y_cnt_q, y_cnt_d, y_min_q, y_min_d, y_max_q, y_max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [Y_W-1:0]   by_min_q, by_min_d, by_max_q, by_max_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             bvalid_q, bvalid_d, bupd_q, bupd_d;
  logic             pix_ev, publish;

  assign pix_ev  = per_frame_vsync & per_frame_href & per_frame_clken & armed_q;
  assign publish = frame_end & armed_q;

  always_comb begin
    armed_d  = armed_q | frame_start;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    x_min_d  = x_min_q;
    x_max_d  = x_max_q;
    y_min_d  = y_min_q;
    y_max_d  = y_max_q;
    cnt_d    = cnt_q;
    bx_min_d = bx_min_q;
    bx_max_d = bx_max_q;
    by_min_d = by_min_q;
    by_max_d = by_max_q;
    bcnt_d   = bcnt_q;
    bvalid_d = bvalid_q;
    bupd_d   = publish;

    if (frame_start) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      cnt_d   = '0;
      x_min_d = '1;
      y_min_d = '1;
      x_max_d = '0;
      y_max_d = '0;
    end else begin
      // Extents compare against the column index before this pixel advances it.
      if (pix_ev) begin
        x_cnt_d = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + X_W'(1);
        if (per_img_bit) begin
          if (x_cnt_q < x_min_q) x_min_d = x_cnt_q;
          if (x_cnt_q > x_max_q) x_max_d = x_cnt_q;
          if (y_cnt_q < y_min_q) y_min_d = y_cnt_q;
          if (y_cnt_q > y_max_q) y_max_d = y_cnt_q;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      if (line_end && per_frame_vsync && armed_q) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == '1) ? y_cnt_q : y_cnt_q + Y_W'(1);
      end
    end

    if (publish) begin
      bcnt_d = cnt_q;
      if (cnt_q >= CNT_W'(MIN_PIXELS)) begin
        bx_min_d = x_min_q;
        bx_max_d = x_max_q;
        by_min_d = y_min_q;
        by_max_d = y_max_q;
        bvalid_d = 1'b1;
      end else begin
        bx_min_d = '0;
        bx_max_d = '0;
        by_min_d = '0;
        by_max_d = '0;
        bvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x_min_q  <= '1;
      y_min_q  <= '1;
      x_max_q  <= '0;
      y_max_q  <= '0;
      cnt_q    <= '0;
      bx_min_q <= '0;
      bx_max_q <= '0;
      by_min_q <= '0;
      by_max_q <= '0;
      bcnt_q   <= '0;
      bvalid_q <= 1'b0;
      bupd_q   <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      x_min_q  <= x_min_d;
      y_min_q  <= y_min_d;
      x_max_q  <= x_max_d;
      y_max_q  <= y_max_d;
      cnt_q    <= cnt_d;
      bx_min_q <= bx_min_d;
      bx_max_q <= bx_max_d;
      by_min_q <= by_min_d;
      by_max_q <= by_max_d;
      bcnt_q   <= bcnt_d;
      bvalid_q <= bvalid_d;
      bupd_q   <= bupd_d;
    end
  end

  assign box_x_min   = bx_min_q;
  assign box_x_max   = bx_max_q;
  assign box_y_min   = by_min_q;
  assign box_y_max   = by_max_q;
  assign box_pix_cnt = bcnt_q;
  assign box_valid   = bvalid_q;
  assign box_update  = bupd_q;
endmodule

// File: tb/tb_bin_bbox_detect.sv
// Directed and random 8x6 frames against a point-list reference, two threshold variants.
module tb_bin_bbox_detect;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 20;
  localparam int FW = 8;
  localparam int FH = 6;
  localparam int THR_A = 4;
  localparam int THR_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0, mb = 1'b0;

  logic [XW-1:0] xmin_a, xmax_a, xmin_b, xmax_b;
  logic [YW-1:0] ymin_a, ymax_a, ymin_b, ymax_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          valid_a, valid_b, upd_a, upd_b;

  bin_bbox_detect #(.X_W(XW), .Y_W(YW), .CNT_W(CW), .MIN_PIXELS(THR_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_bit(mb),
    .box_x_min(xmin_a), .box_x_max(xmax_a), .box_y_min(ymin_a), .box_y_max(ymax_a),
    .box_pix_cnt(cnt_a), .box_valid(valid_a), .box_update(upd_a)
  );

  bin_bbox_detect #(.X_W(XW), .Y_W(YW), .CNT_W(CW), .MIN_PIXELS(THR_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_bit(mb),
    .box_x_min(xmin_b), .box_x_max(xmax_b), .box_y_min(ymin_b), .box_y_max(ymax_b),
    .box_pix_cnt(cnt_b), .box_valid(valid_b), .box_update(upd_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pubs = 0;

  always @(negedge clk) begin
    if (upd_a) pulses_a++;
    if (upd_b) pulses_b++;
  end

  bit fm [0:FW-1][0:FH-1];
  int px_x[$];
  int px_y[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic c, input logic b);
    vs = v; hr = h; ce = c; mb = b;
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_fm();
    for (int x = 0; x < FW; x++)
      for (int y = 0; y < FH; y++) fm[x][y] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " xmin_a"}, 32'(xmin_a), 0);
    check({tag, " xmax_a"}, 32'(xmax_a), 0);
    check({tag, " ymin_a"}, 32'(ymin_a), 0);
    check({tag, " ymax_a"}, 32'(ymax_a), 0);
    check({tag, " cnt_a"},  32'(cnt_a),  0);
    check({tag, " valid_a"}, 32'(valid_a), 0);
    check({tag, " cnt_b"},  32'(cnt_b),  0);
    check({tag, " valid_b"}, 32'(valid_b), 0);
  endtask

  // Active pixels with random clken gaps and href-low noise; mask pixels
  // actually delivered are recorded as (column, row) points.
  task automatic send_lines(input int r0, input int r1, input bit record);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < FW; c++) begin
        if ($urandom_range(0, 3) == 0) drive(1, 1, 0, 1);
        if (record && fm[c][r]) begin
          px_x.push_back(c);
          px_y.push_back(r);
        end
        drive(1, 1, 1, fm[c][r]);
      end
      drive(1, 0, 1, 1);
      drive(1, 0, 0, 0);
    end
  endtask

  task automatic send_frame();
    px_x.delete();
    px_y.delete();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    send_lines(0, FH, 1'b1);
    drive(0, 1, 1, 1);
  endtask

  task automatic check_side(input string tag, input int thr, input int n,
                            input int x0, input int x1, input int y0, input int y1,
                            input logic [XW-1:0] oxmin, input logic [XW-1:0] oxmax,
                            input logic [YW-1:0] oymin, input logic [YW-1:0] oymax,
                            input logic [CW-1:0] ocnt, input logic ovalid, input logic oupd);
    bit v;
    v = (n >= thr);
    check({tag, " upd"},   32'(oupd), 1);
    check({tag, " cnt"},   32'(ocnt), n);
    check({tag, " valid"}, 32'(ovalid), 32'(v));
    check({tag, " xmin"},  32'(oxmin), v ? x0 : 0);
    check({tag, " xmax"},  32'(oxmax), v ? x1 : 0);
    check({tag, " ymin"},  32'(oymin), v ? y0 : 0);
    check({tag, " ymax"},  32'(oymax), v ? y1 : 0);
  endtask

  task automatic check_pub(input string tag);
    int n, x0, x1, y0, y1;
    n = px_x.size();
    x0 = 1 << 30; x1 = -1; y0 = 1 << 30; y1 = -1;
    foreach (px_x[i]) begin
      if (px_x[i] < x0) x0 = px_x[i];
      if (px_x[i] > x1) x1 = px_x[i];
      if (px_y[i] < y0) y0 = px_y[i];
      if (px_y[i] > y1) y1 = px_y[i];
    end
    pubs++;
    check_side({tag, "_a"}, THR_A, n, x0, x1, y0, y1,
               xmin_a, xmax_a, ymin_a, ymax_a, cnt_a, valid_a, upd_a);
    check_side({tag, "_b"}, THR_B, n, x0, x1, y0, y1,
               xmin_b, xmax_b, ymin_b, ymax_b, cnt_b, valid_b, upd_b);
    drive(0, 0, 0, 0);
    check({tag, " pulse_end_a"}, 32'(upd_a), 0);
    check({tag, " pulse_end_b"}, 32'(upd_b), 0);
    check({tag, " hold_cnt_a"},  32'(cnt_a), n);
    drive(0, 0, 0, 0);
    check({tag, " pulses_a"}, pulses_a, pubs);
    check({tag, " pulses_b"}, pulses_b, pubs);
  endtask

  initial begin
    // Reset with vsync already high: the partial frame must be discarded.
    vs = 1'b1; hr = 1'b0;
    step(); step();
    check("rst upd_a", 32'(upd_a), 0);
    check_zero("rst");
    rst_n = 1'b1;
    clear_fm();
    fm[1][3] = 1'b1; fm[4][4] = 1'b1; fm[6][5] = 1'b1; fm[2][2] = 1'b1; fm[5][3] = 1'b1;
    send_lines(2, FH, 1'b0);
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("partial pulses_a", pulses_a, 0);
    check("partial pulses_b", pulses_b, 0);
    check_zero("partial");

    // Four-pixel frame: box x 2..5, y 1..4.
    clear_fm();
    fm[2][1] = 1'b1; fm[5][1] = 1'b1; fm[3][4] = 1'b1; fm[2][3] = 1'b1;
    send_frame();
    check("dir4 n", px_x.size(), 4);
    check_pub("dir4");

    // Three pixels: below THR_A, above THR_B.
    fm[3][4] = 1'b0;
    send_frame();
    check_pub("dir3");

    // Single pixel in the far corner; no stale extents may survive.
    clear_fm();
    fm[7][5] = 1'b1;
    send_frame();
    check_pub("single");

    // Empty frame.
    clear_fm();
    send_frame();
    check_pub("empty");

    // Random masks of varying density.
    for (int f = 0; f < 8; f++) begin
      int dens;
      dens = $urandom_range(2, 12);
      for (int x = 0; x < FW; x++)
        for (int y = 0; y < FH; y++) fm[x][y] = ($urandom_range(0, dens) == 0);
      send_frame();
      check_pub($sformatf("rand%0d", f));
    end

    // Reset mid-frame after three mask pixels.
    clear_fm();
    fm[0][0] = 1'b1; fm[3][0] = 1'b1; fm[6][1] = 1'b1;
    drive(1, 0, 0, 0);
    send_lines(0, 2, 1'b0);
    rst_n = 1'b0;
    step(); step();
    check_zero("midrst");
    rst_n = 1'b1;
    fm[4][3] = 1'b1;
    send_lines(2, FH, 1'b0);
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("midrst pulses_a", pulses_a, pubs);
    check_zero("midrst_end");

    clear_fm();
    fm[1][0] = 1'b1; fm[6][2] = 1'b1; fm[3][3] = 1'b1; fm[0][5] = 1'b1; fm[7][4] = 1'b1;
    send_frame();
    check("post_rst n", px_x.size(), 5);
    check_pub("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
